// File: rtl/peripheral_showresult_pkg.sv
// Shared types and constants for the peripheral display path.
//   state_t    : display FSM states (IDLE, SHOW)
//   word_sel_t : snapshot word selector (A=0, B=1, R=2; 3 is unused)
//   SEG_*      : active-low seven-segment glyphs, bit order {g,f,e,d,c,b,a}
package peripherals_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        WORD_A = 2'd0,
        WORD_B = 2'd1,
        WORD_R = 2'd2
    } word_sel_t;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_LTR_A = 7'b0001000;
    localparam logic [6:0] SEG_LTR_B = 7'b0000011;
    localparam logic [6:0] SEG_LTR_R = 7'b0101111;

endpackage

// File: rtl/peripheral_showresult_hex7seg.sv
// hex7seg: combinational 4-bit nibble to active-low seven-segment font.
//   nibble in  4 : value to display
//   seg    out 7 : active-low segments {g,f,e,d,c,b,a}
module hex7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/peripheral_showresult.sv
// peripheral_showresult: snapshots A/B/R on start, then steps one byte per
// enter press through A[7:0]..R[31:24], showing each byte on four
// active-low seven-segment displays and on a parallel byte port.
//   clk, reset (async, active-high)
//   enter            : raw push-button level (asynchronous)
//   start            : one-cycle data-ready strobe, accepted only in IDLE
//   dataA/dataB/dataR: words sampled on accepted start
//   outputdata       : selected byte (0x00 in IDLE)
//   outputdata_valid : high in SHOW
//   busy             : high in SHOW
//   disp3..disp0     : word letter, byte index, high nibble, low nibble
module peripheral_showresult
    import peripherals_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enter,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [31:0] dataR,
    output logic [7:0]  outputdata,
    output logic        outputdata_valid,
    output logic        busy,
    output logic [6:0]  disp3,
    output logic [6:0]  disp2,
    output logic [6:0]  disp1,
    output logic [6:0]  disp0
);

    state_t      state, state_nxt;
    word_sel_t   word_sel, word_sel_nxt;
    logic [1:0]  byte_sel, byte_sel_nxt;
    logic        load;
    logic [31:0] snap_a, snap_b, snap_r;
    logic        enter_s1, enter_s2, enter_d;
    logic        enterpulse;
    logic [31:0] cur_word;
    logic [6:0]  seg_byte, seg_hi, seg_lo;

    // Two-flop synchronizer followed by a rising-edge detector.
    assign enterpulse = enter_s2 & ~enter_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_s1 <= 1'b0;
            enter_s2 <= 1'b0;
            enter_d  <= 1'b0;
        end else begin
            enter_s1 <= enter;
            enter_s2 <= enter_s1;
            enter_d  <= enter_s2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            word_sel <= WORD_A;
            byte_sel <= 2'd0;
            snap_a   <= '0;
            snap_b   <= '0;
            snap_r   <= '0;
        end else begin
            state    <= state_nxt;
            word_sel <= word_sel_nxt;
            byte_sel <= byte_sel_nxt;
            if (load) begin
                snap_a <= dataA;
                snap_b <= dataB;
                snap_r <= dataR;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        word_sel_nxt = word_sel;
        byte_sel_nxt = byte_sel;
        load         = 1'b0;
        case (state)
            IDLE: begin
                // start takes priority; a coincident enterpulse is dropped.
                if (start) begin
                    load         = 1'b1;
                    word_sel_nxt = WORD_A;
                    byte_sel_nxt = 2'd0;
                    state_nxt    = SHOW;
                end
            end
            SHOW: begin
                if (word_sel != WORD_A && word_sel != WORD_B && word_sel != WORD_R) begin
                    // Unused selector encoding: recover to IDLE.
                    state_nxt    = IDLE;
                    word_sel_nxt = WORD_A;
                    byte_sel_nxt = 2'd0;
                end else if (enterpulse) begin
                    if (byte_sel == 2'd3) begin
                        byte_sel_nxt = 2'd0;
                        case (word_sel)
                            WORD_A:  word_sel_nxt = WORD_B;
                            WORD_B:  word_sel_nxt = WORD_R;
                            default: begin
                                word_sel_nxt = WORD_A;
                                state_nxt    = IDLE;
                            end
                        endcase
                    end else begin
                        byte_sel_nxt = byte_sel + 2'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cur_word = '0;
        case (word_sel)
            WORD_A:  cur_word = snap_a;
            WORD_B:  cur_word = snap_b;
            WORD_R:  cur_word = snap_r;
            default: cur_word = '0;
        endcase
    end

    assign busy             = (state == SHOW);
    assign outputdata_valid = (state == SHOW);
    assign outputdata       = (state == SHOW) ? cur_word[{byte_sel, 3'b000} +: 8] : 8'h00;

    hex7seg u_hex_byte (.nibble({2'b00, byte_sel}), .seg(seg_byte));
    hex7seg u_hex_hi   (.nibble(outputdata[7:4]),   .seg(seg_hi));
    hex7seg u_hex_lo   (.nibble(outputdata[3:0]),   .seg(seg_lo));

    always_comb begin
        disp3 = SEG_DASH;
        disp2 = SEG_DASH;
        disp1 = SEG_DASH;
        disp0 = SEG_DASH;
        if (state == SHOW) begin
            case (word_sel)
                WORD_A:  disp3 = SEG_LTR_A;
                WORD_B:  disp3 = SEG_LTR_B;
                WORD_R:  disp3 = SEG_LTR_R;
                default: disp3 = SEG_DASH;
            endcase
            disp2 = seg_byte;
            disp1 = seg_hi;
            disp0 = seg_lo;
        end
    end

endmodule

// File: doc/peripheral_showresult.md
# peripheral_showresult

Output-side companion to the operand loader. On a `start` pulse it snapshots the three 32-bit words (A, B, R). Each debounced-free, synchronized `enter` press then steps one byte at a time through A[7:0]…A[31:24], B…, R…. Each byte is shown on four active-low seven-segment displays and driven on a parallel byte port. It sits between the ALU result path and the board's HEX displays, replacing ad-hoc display muxing in `peripherals`.

## Interface
- No parameters; all widths fixed.
- `clk` in 1: single system clock.
- `reset` in 1: asynchronous, active-high.
- `enter` in 1: raw push-button level, asynchronous to `clk`, active-high.
- `start` in 1: synchronous, one-cycle "data ready" strobe from the loader/ALU.
- `dataA`, `dataB`, `dataR` in 32: words to display, sampled only on accepted `start`.
- `outputdata` out 8: byte currently selected.
- `outputdata_valid` out 1: high while in SHOW.
- `busy` out 1: high while in SHOW; `start` is ignored while high.
- `disp3..disp0` out 7: active-low segments, bit order {g,f,e,d,c,b,a}.

## Operation
- Enter conditioning: 2-flop synchronizer, then a rising-edge detector, gives a one-cycle `enterpulse`. A held button yields exactly one step.
- FSM states: IDLE, SHOW.
- IDLE:
  - `start`=1 copies A/B/R into snapshot registers.
  - Sets `word_sel`=A and `byte_sel`=0, then moves to SHOW.
  - `enterpulse` is ignored.
- SHOW, on `enterpulse`:
  - `byte_sel` increments.
  - When `byte_sel`=3, it wraps to 0 and `word_sel` advances A→B→R.
  - At R byte 3, returns to IDLE.
  - Exactly 12 presses take SHOW→IDLE.
- SHOW ignores `start`. Snapshots hold, so upstream may change A/B/R freely.
- `outputdata` = snapshot[word_sel][byte_sel*8 +: 8]. It is 0x00 in IDLE.
- Display content in SHOW:
  - `disp3` = word letter: A=0001000, b=0000011, r=0101111.
  - `disp2` = hex digit of `byte_sel`.
  - `disp1` = high nibble of `outputdata`.
  - `disp0` = low nibble of `outputdata`.
- Display content in IDLE: all four displays show dash 0111111.
- Hex font, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- `word_sel` encoding 2'b11 is unreachable. If reached, force IDLE on the next clock.

## Timing
- Reset (async, any state):
  - FSM=IDLE.
  - Snapshots, `word_sel` and `byte_sel` = 0.
  - Synchronizer and edge flops = 0.
  - `busy`=0, `outputdata_valid`=0, `outputdata`=0x00, all displays show dash.
- Reset mid-SHOW abandons the sequence. A new `start` is required afterward.
- `start` high at edge k (IDLE): state, snapshots and outputs are updated after edge k. The first byte is visible in the cycle following k.
- `enter` first sampled high at edge k: `enterpulse` is high in the cycle after edge k+1, and indices update at edge k+2.
  - Outputs are combinational from registers, so they are valid after edge k+2 (3-cycle latency).
- `enter` low pulses shorter than one clock may be missed. This is acceptable.
- Simultaneous `start` and `enterpulse` in IDLE: start wins and the pulse is dropped (first byte is shown).
- Final step from R byte 3: `busy` falls after the same edge that updates the indices.

## Structure
- Shared package `peripherals_pkg`:
  - `state_t` enum {IDLE, SHOW}.
  - `word_sel_t` (2 bits: A=0, B=1, R=2).
  - Segment constants SEG_DASH, SEG_LTR_A, SEG_LTR_B, SEG_LTR_R.
- One sub-module, `hex7seg`: a 4-bit nibble to 7-bit active-low combinational font. It is instantiated three times (disp2, disp1, disp0).
- Synchronizer and edge detector stay inline.

## Test plan
- Reset then idle: all displays = 0111111, `busy`=0, `outputdata`=0x00. Pressing `enter` 3 times leaves all outputs unchanged.
- Sequence, with A=0x12345678, B=0xCAFEBABE, R=0xDEADBEEF and a `start` pulse:
  - Immediately: `outputdata`=0x78, disp3=0001000, disp2=1000000, disp1=1111000, disp0=0000000.
  - Press 12 times: bytes are 78,56,34,12,BE,BA,FE,CA,EF,BE,AD,DE.
  - After the 12th press: IDLE, `busy`=0.
- Snapshot hold: after `start`, change dataA to 0xFFFFFFFF and press 3 times → bytes are 56,34,12. A `start` asserted during SHOW is ignored.
- Enter held high for 50 cycles → exactly one step, and `byte_sel` changes exactly 3 cycles after the first sampled high.
- Async reset asserted mid-edge while showing B byte 2 → immediate IDLE, all displays dash, `outputdata`=0x00. Subsequent presses do nothing until `start`.
- `start` and an `enterpulse` in the same IDLE cycle → shows A byte 0 (0x78), not byte 1.
